// File: rtl/seven_seg_display_scanner_if.sv
// Bundle between the clock counter chain (master) and the 4-digit display
// scanner (slave): BCD time digits and blink requests in, board pin levels out.
interface seven_seg_display_scanner_if;
  logic [3:0] counter1;
  logic [2:0] counter2;
  logic [3:0] counter3;
  logic [1:0] counter4;
  logic [5:0] counter_seconds;
  logic       blink_min;
  logic       blink_hr;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output counter1, counter2, counter3, counter4, counter_seconds,
    output blink_min, blink_hr,
    input  anode, seg, dp
  );

  modport slave (
    input  counter1, counter2, counter3, counter4, counter_seconds,
    input  blink_min, blink_hr,
    output anode, seg, dp
  );
endinterface

// File: rtl/seven_seg_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with field blinking,
// colon flash and a dead slot per digit. Optional: LEADING_ZERO_BLANK_EN.
module seven_seg_display_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 50000000
) (
  input  logic                          clk_out,
  input  logic                          reset,
  seven_seg_display_scanner_if.slave    disp
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]    index_q, index_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          refresh_last;
  logic          blink_last;
  logic [3:0]    digit;
  logic          group_blink;

  // Active-high segment pattern; illegal BCD returns all segments off.
  function automatic logic [6:0] seg_pattern(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    refresh_last  = (refresh_cnt_q == REFRESH_LAST);
    refresh_cnt_d = refresh_last ? '0 : refresh_cnt_q + 1'b1;
    index_d       = refresh_last ? index_q + 2'd1 : index_q;

    blink_last    = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d   = blink_last ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_last ? ~blink_phase_q : blink_phase_q;

    case (index_q)
      2'd0:    digit = disp.counter1;
      2'd1:    digit = {1'b0, disp.counter2};
      2'd2:    digit = disp.counter3;
      default: digit = {2'b00, disp.counter4};
    endcase
    group_blink = index_q[1] ? disp.blink_hr : disp.blink_min;

    anode_d = 4'b1111;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    // Last count of each slot stays dark to stop the next digit ghosting.
    if (!refresh_last) begin
      anode_d = ~(4'b0001 << index_q);
      seg_d   = ~seg_pattern(digit);
      dp_d    = !(index_q == 2'd2 && !disp.counter_seconds[0]);
      if (!blink_phase_q && group_blink) anode_d = 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
      if (index_q == 2'd3 && disp.counter4 == 2'd0) anode_d = 4'b1111;
`endif
    end
  end

  always_ff @(posedge clk_out) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      refresh_cnt_q <= '0;
      index_q       <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      anode_q       <= 4'b1111;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      index_q       <= index_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign disp.anode = anode_q;
  assign disp.seg   = seg_q;
  assign disp.dp    = dp_q;

endmodule

// File: tb/tb_seven_seg_display_scanner.sv
// Randomised self-checking bench for seven_seg_display_scanner against a
// cycle-index reference model (REFRESH_DIV=4, BLINK_DIV=16).
module tb_seven_seg_display_scanner;

  localparam int RD = 4;
  localparam int BD = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   k;

  seven_seg_display_scanner_if dif ();

  seven_seg_display_scanner #(
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD)
  ) dut (
    .clk_out (clk),
    .reset   (reset),
    .disp    (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] pat [10];
  initial begin
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F; pat[4] = 7'h66;
    pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07; pat[8] = 7'h7F; pat[9] = 7'h6F;
  end

  // Expected pins after edge number n since reset release, from the current inputs.
  function automatic void model(input int n, output logic [3:0] a, output logic [6:0] s,
                                output logic d);
    int pos, idx, val;
    bit visible, blk;
    pos     = n % RD;
    idx     = (n / RD) % 4;
    visible = ((n / BD) % 2) == 0;
    a = 4'b1111; s = 7'h7F; d = 1'b1;
    if (pos != RD - 1) begin
      case (idx)
        0:       val = int'(dif.counter1);
        1:       val = int'(dif.counter2);
        2:       val = int'(dif.counter3);
        default: val = int'(dif.counter4);
      endcase
      a[idx] = 1'b0;
      s = (val > 9) ? 7'h7F : ~pat[val];
      d = !(idx == 2 && (dif.counter_seconds % 2) == 0);
      blk = (idx < 2) ? dif.blink_min : dif.blink_hr;
      if (!visible && blk) a = 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx == 3 && dif.counter4 == 2'd0) a = 4'b1111;
`endif
    end
  endfunction

  task automatic step(input string name);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    @(posedge clk); #1;
    model(k, ea, es, ed);
    checks += 3;
    if (dif.anode !== ea) begin
      errors++;
      $display("FAIL %s anode k=%0d: got %b expected %b", name, k, dif.anode, ea);
    end
    if (dif.seg !== es) begin
      errors++;
      $display("FAIL %s seg k=%0d: got %b expected %b", name, k, dif.seg, es);
    end
    if (dif.dp !== ed) begin
      errors++;
      $display("FAIL %s dp k=%0d: got %b expected %b", name, k, dif.dp, ed);
    end
    k++;
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (dif.anode !== 4'b1111 || dif.seg !== 7'h7F || dif.dp !== 1'b1) begin
      errors++;
      $display("FAIL %s: got anode=%b seg=%b dp=%b expected 1111 1111111 1",
               name, dif.anode, dif.seg, dif.dp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    dif.counter1 = 4'd7; dif.counter2 = 3'd3; dif.counter3 = 4'd2; dif.counter4 = 2'd1;
    dif.counter_seconds = 6'd0; dif.blink_min = 1'b0; dif.blink_hr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    reset = 1'b1;
    k = 0;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 2 * 4 * RD; i++) step("scan_7321");
  endtask

  task automatic test_dp();
    for (int i = 0; i < 48; i++) begin
      dif.counter_seconds = ($urandom_range(0, 1) == 0) ? 6'd10 : 6'd11;
      step("dp_colon");
    end
  endtask

  task automatic test_blink();
    dif.counter_seconds = 6'd11;
    dif.blink_min = 1'b1;
    for (int i = 0; i < 4 * BD; i++) step("blink_min");
    dif.blink_hr = 1'b1;
    for (int i = 0; i < 4 * BD; i++) step("blink_both");
    dif.blink_min = 1'b0;
    dif.blink_hr  = 1'b0;
  endtask

  task automatic test_illegal_bcd();
    dif.counter1 = 4'hB;
    for (int i = 0; i < 4 * RD; i++) step("illegal_bcd");
    dif.counter1 = 4'hF;
    for (int i = 0; i < 4 * RD; i++) step("illegal_bcd_f");
    dif.counter1 = 4'd7;
  endtask

  task automatic test_leading_zero();
    dif.counter4 = 2'd0;
    for (int i = 0; i < 2 * 4 * RD; i++) step("hours_tens_zero");
    dif.counter4 = 2'd1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      dif.counter1        = 4'($urandom_range(0, 15));
      dif.counter2        = 3'($urandom_range(0, 7));
      dif.counter3        = 4'($urandom_range(0, 15));
      dif.counter4        = 2'($urandom_range(0, 3));
      dif.counter_seconds = 6'($urandom_range(0, 59));
      dif.blink_min       = ($urandom_range(0, 7) == 0);
      dif.blink_hr        = ($urandom_range(0, 7) == 0);
      step("random");
    end
  endtask

  task automatic test_reset_mid_scan();
    int guard;
    dif.blink_min = 1'b0;
    dif.blink_hr  = 1'b0;
    guard = 0;
    while (!(((k / RD) % 4) == 2 && (k % RD) == 1) && guard < 64) begin
      step("pre_reset");
      guard++;
    end
    checks++;
    if (guard >= 64) begin
      errors++;
      $display("FAIL reset_mid_align: got guard=%0d expected <64", guard);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_values("reset_mid_scan");
    reset = 1'b1;
    k = 0;
    dif.blink_min = 1'b1;
    for (int i = 0; i < 2 * BD + 4; i++) step("after_reset");
    dif.blink_min = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    k = 0;
    test_reset();
    test_scan();
    test_dp();
    test_blink();
    test_illegal_bcd();
    test_leading_zero();
    test_random();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
